// File: rtl/tdr_latch_bank.sv
// tdr_latch_bank: multi-channel time-domain register.
// Each channel holds a set-once carry flag and the run-counter value at its
// first event after arming. A three-state controller (IDLE/RUN/DONE) arms the
// bank, closes the capture window on completion or timeout, and re-arms on
// start.
// Configuration macro: TDR_LATCH_BANK_EDGE_EN
//   defined   -> rising-edge event detection using a 1-cycle history register
//   undefined -> level-sensitive event detection, no history register built
module tdr_latch_bank #(
   parameter int N_CH    = 4,
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rstb,
   input  logic                  start,
   input  logic [N_CH-1:0]       ev,
   output logic [N_CH-1:0]       carry,
   output logic [N_CH-1:0]       carry_b,
   output logic [N_CH*CNT_W-1:0] stamp,
   output logic [CNT_W-1:0]      cnt,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout,
   output logic [1:0]            state_dbg
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   state_t                  state_q, state_d;
   logic [N_CH-1:0]         carry_q, carry_d;
   logic [N_CH*CNT_W-1:0]   stamp_q, stamp_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    timeout_q, timeout_d;
   logic [N_CH-1:0]         hit;

`ifdef TDR_LATCH_BANK_EDGE_EN
   logic [N_CH-1:0]         ev_hist_q, ev_hist_d;

   // History of ev follows the input every cycle, in every state.
   always_comb begin
      ev_hist_d = ev;
   end

   // History register for rising-edge detection.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) ev_hist_q <= '0;
      else       ev_hist_q <= ev_hist_d;
   end

   // A hit is a low-to-high transition of the event input.
   always_comb begin
      hit = ev & ~ev_hist_q;
   end
`else
   // A hit is simply the event level.
   always_comb begin
      hit = ev;
   end
`endif

   // Controller next-state and per-channel capture logic.
   always_comb begin
      state_d   = state_q;
      carry_d   = carry_q;
      stamp_d   = stamp_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            // Arming clears the bank; events on the arming edge are dropped.
            if (start) begin
               carry_d   = '0;
               stamp_d   = '0;
               cnt_d     = '0;
               timeout_d = 1'b0;
               state_d   = ST_RUN;
            end
         end
         ST_RUN: begin
            for (int i = 0; i < N_CH; i++) begin
               if (hit[i] && !carry_q[i]) begin
                  carry_d[i]                = 1'b1;
                  stamp_d[i*CNT_W +: CNT_W] = cnt_q;
               end
            end
            // Saturate so the counter cannot wrap when TIMEOUT is all ones.
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            // Completion wins over timeout on the same edge.
            if (&carry_d) begin
               state_d   = ST_DONE;
               timeout_d = 1'b0;
            end else if (cnt_q == TIMEOUT_C) begin
               state_d   = ST_DONE;
               timeout_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q   <= ST_IDLE;
         carry_q   <= '0;
         stamp_q   <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         carry_q   <= carry_d;
         stamp_q   <= stamp_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   // Outputs are direct decodes of the registered state.
   always_comb begin
      carry     = carry_q;
      carry_b   = ~carry_q;
      stamp     = stamp_q;
      cnt       = cnt_q;
      busy      = (state_q == ST_RUN);
      done      = (state_q == ST_DONE);
      timeout   = timeout_q;
      state_dbg = state_q;
   end

endmodule
